// File: rtl/regfile_fifo_ctrl.sv
// FIFO controller for an external separate-port register file: pointers, occupancy, flags.
// Optional one-entry registered output stage enabled by defining REGFILE_FIFO_CTRL_OUT_REG_EN.

module regfile_fifo_ctrl #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int AW    = $clog2(N),
  localparam int LW    = $clog2(N + 2)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty,
  output logic             rf_write_en,
  output logic [AW-1:0]    rf_write_addr,
  output logic [WIDTH-1:0] rf_data_in,
  output logic             rf_read_en,
  output logic [AW-1:0]    rf_read_addr,
  input  logic [WIDTH-1:0] rf_data_out
);

  localparam logic [LW-1:0] CNT_FULL = LW'(N);
`ifdef REGFILE_FIFO_CTRL_OUT_REG_EN
  localparam logic [LW-1:0] CAPACITY = LW'(N + 1);
`else
  localparam logic [LW-1:0] CAPACITY = LW'(N);
`endif

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_cnt;

  logic          w_push;
  logic          w_pop;
  logic          w_deq;
  logic          w_cnt_nz;
  logic [LW-1:0] w_cnt_nxt;
  logic [LW-1:0] w_level;

  assign w_cnt_nz = (r_cnt != '0);
  // A full register file refuses a push even when a pop frees a slot this cycle.
  assign in_ready = rstn & (r_cnt != CNT_FULL);
  assign w_push   = in_valid & in_ready;
  assign w_pop    = out_valid & out_ready;

`ifdef REGFILE_FIFO_CTRL_OUT_REG_EN
  logic             r_ov;
  logic [WIDTH-1:0] r_od;

  // Refill the output stage whenever it is empty or being drained this cycle.
  assign w_deq = w_cnt_nz & (~r_ov | w_pop);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ov <= 1'b0;
      r_od <= '0;
    end else if (w_deq) begin
      r_ov <= 1'b1;
      r_od <= rf_data_out;
    end else if (w_pop) begin
      r_ov <= 1'b0;
    end
  end

  assign out_valid = r_ov;
  assign out_data  = r_od;
  assign w_level   = r_cnt + {{(LW-1){1'b0}}, r_ov};
`else
  assign w_deq     = w_pop;
  assign out_valid = w_cnt_nz;
  assign out_data  = rf_data_out;
  assign w_level   = r_cnt;
`endif

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_deq})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // NOTE: reset is synchronous, so it sits inside the clocked branch and the sensitivity list is clk only.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign level         = w_level;
  assign full          = (w_level == CAPACITY);
  assign empty         = ~out_valid;
  assign rf_write_en   = w_push;
  assign rf_write_addr = r_wr_ptr;
  assign rf_data_in    = in_data;
  assign rf_read_en    = w_cnt_nz;
  assign rf_read_addr  = r_rd_ptr;

endmodule

// File: tb/tb_regfile_fifo_ctrl.sv
// Scoreboard bench for regfile_fifo_ctrl with a behavioural register file attached.
// Honours REGFILE_FIFO_CTRL_OUT_REG_EN for capacity and latency expectations.

module tb_regfile_fifo_ctrl;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int AW    = $clog2(N);
  localparam int LW    = $clog2(N + 2);
`ifdef REGFILE_FIFO_CTRL_OUT_REG_EN
  localparam int CAP = N + 1;
  localparam int LAT = 2;
`else
  localparam int CAP = N;
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [LW-1:0]    level;
  logic             full;
  logic             empty;
  logic             rf_write_en;
  logic [AW-1:0]    rf_write_addr;
  logic [WIDTH-1:0] rf_data_in;
  logic             rf_read_en;
  logic [AW-1:0]    rf_read_addr;
  logic [WIDTH-1:0] rf_data_out;

  regfile_fifo_ctrl #(.WIDTH(WIDTH), .N(N)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .rf_write_en  (rf_write_en),
    .rf_write_addr(rf_write_addr),
    .rf_data_in   (rf_data_in),
    .rf_read_en   (rf_read_en),
    .rf_read_addr (rf_read_addr),
    .rf_data_out  (rf_data_out)
  );

  // Behavioural register file: clocked write, combinational read gated by read_en.
  logic [WIDTH-1:0] rf_mem [N];
  always @(posedge clk) if (rf_write_en) rf_mem[rf_write_addr] <= rf_data_in;
  assign rf_data_out = rf_read_en ? rf_mem[rf_read_addr] : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_fail   = 0;
  int               n_pops   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] pop_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: inputs are stable mid-cycle, so negedge shows what the next posedge will do.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_pops++;
        pop_log.push_back(out_data);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got 0x%0h, expected no output", out_data);
        end else begin
          check("pop_data", out_data, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (empty && exp_q.size() == 0) break;
      tick();
    end
    check("drain_empty", empty, 1);
    check("drain_sb_empty", exp_q.size(), 0);
    out_ready = 1'b0;
  endtask

  int p0;
  int pl;

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    check("in_ready_in_reset", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 32'hFF;
    #1;
    check("wr_en_in_reset", rf_write_en, 0);
    in_valid = 1'b0;
    tick();
    rstn = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_rf_write_en", rf_write_en, 0);
    check("rst_rf_read_en", rf_read_en, 0);

    // Fill to capacity with consecutive pushes.
    for (int i = 0; i < CAP; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + i;
      #1;
      check("fill_in_ready", in_ready, 1);
      tick();
    end
    in_data = 32'hA0 + CAP;
    repeat (2) begin
      #1;
      check("held_in_ready", in_ready, 0);
      check("held_level", level, CAP);
      check("held_full", full, 1);
      tick();
    end

    // Full with a pop pending: pop only, push accepted one cycle later.
    out_ready = 1'b1;
    #1;
    check("full_pop_in_ready", in_ready, 0);
    tick();
    check("after_pop_level", level, CAP - 1);
    check("after_pop_in_ready", in_ready, 1);
    tick();
    check("push_pop_level", level, CAP - 1);
    in_valid = 1'b0;
    drain();
    check("fill_pops", n_pops, CAP + 1);
    check("drained_out_valid", out_valid, 0);
    check("drained_level", level, 0);

    // Sustained streaming at level 2 across several pointer wraps.
    in_valid = 1'b1;
    in_data  = 32'd1;
    tick();
    in_data = 32'd2;
    tick();
    check("stream_start_level", level, 2);
    out_ready = 1'b1;
    p0 = n_pops;
    for (int v = 3; v <= 12; v++) begin
      in_data = v;
      tick();
      check("stream_level", level, 2);
      check("stream_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    check("stream_no_bubbles", n_pops - p0, 10);
    drain();

    // Latency of a single push into an empty FIFO.
    in_valid = 1'b1;
    in_data  = 32'h11;
    tick();
    in_valid = 1'b0;
    check("lat_first_edge_valid", out_valid, (LAT == 1));
    check("lat_level", level, 1);
    tick();
    check("lat_second_edge_valid", out_valid, 1);
    check("lat_data", out_data, 32'h11);

    // Reset mid-stream at level 3 discards everything.
    in_valid = 1'b1;
    in_data  = 32'h12;
    tick();
    in_data = 32'h13;
    tick();
    in_valid = 1'b0;
    check("pre_reset_level", level, 3);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    #1;
    check("midrst_level", level, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_empty", empty, 1);
    check("midrst_in_ready", in_ready, 1);
    pl = pop_log.size();
    in_valid = 1'b1;
    in_data  = 32'h55;
    tick();
    in_data = 32'h66;
    tick();
    in_valid = 1'b0;
    drain();
    check("post_reset_pop_count", pop_log.size(), pl + 2);
    if (pop_log.size() > pl) check("post_reset_first", pop_log[pl], 32'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regfile_fifo_ctrl.md
# regfile_fifo_ctrl

Synchronous FIFO controller built around the team's separate-port register file (one write port, one combinationally read port, synchronous clear). It sits directly upstream of that register file and drives its write and read ports. It turns a valid/ready stream on the input side into a valid/ready stream on the output side. It owns the write and read pointers, the occupancy count and the full/empty flags; all storage stays in the register file instance.

## Interface
- WIDTH, 32, data width; must match the register file WIDTH.
- N, 4, register file depth; power of two, ≥ 2; must match the register file N.
- Derived: AW = $clog2(N); LW = $clog2(N+2).
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  producer has data.
- in_ready  out  1  controller accepts data this cycle.
- in_data  in  WIDTH  producer data.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer takes head this cycle.
- out_data  out  WIDTH  head entry.
- level  out  LW  entries held (register file plus output stage if present).
- full  out  1  no space.
- empty  out  1  nothing to deliver.
- rf_write_en  out  1  to register file write_en.
- rf_write_addr  out  AW  to register file write_addr.
- rf_data_in  out  WIDTH  to register file data_in.
- rf_read_en  out  1  to register file read_en.
- rf_read_addr  out  AW  to register file read_addr.
- rf_data_out  in  WIDTH  from register file data_out (combinational read).

## Operation
- push = in_valid & in_ready. pop = out_valid & out_ready.
- State: wr_ptr and rd_ptr (AW bits each, wrap N-1 → 0 naturally) and cnt (0..N, register-file occupancy).
- in_ready = rstn & (cnt != N). A full FIFO does not accept a push even when a pop happens in the same cycle. There is no write-through bypass.
- On push: rf_write_en=1, rf_write_addr=wr_ptr, rf_data_in=in_data; wr_ptr++.
- The register-file read port always addresses rd_ptr. rf_read_en=1 whenever cnt != 0, so rf_data_out reads 0 when the register file is empty.
- Base build (macro off):
  - out_valid = (cnt != 0).
  - out_data = rf_data_out.
  - On pop: rd_ptr++.
- cnt update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, and both pointers advance.
- level = cnt; full = (level == capacity); empty = ~out_valid.
- In_data arriving while full is held by the producer. The controller never drops or overwrites data.
- Reset (rstn low at posedge): wr_ptr=0, rd_ptr=0, cnt=0, output stage empty.
  - Outputs after reset: in_ready=1, out_valid=0, out_data=0, level=0, full=0, empty=1, rf_write_en=0, rf_read_en=0.
  - While rstn is low: in_ready=0 and rf_write_en=0.
  - Reset mid-stream discards all entries. The contents of the register file are not relied upon.

## Timing
- Input-to-output latency: 1 cycle in the base build. Data pushed at edge k is presented with out_valid=1 after edge k.
- Throughput is one push and one pop per cycle sustained while 0 < cnt < N.
- Combinational paths in the base build:
  - out_ready → in_ready: none (in_ready depends on cnt only).
  - in_valid → out_valid: none.
- All state changes occur on the posedge of clk only.

## Configuration
- Macro: REGFILE_FIFO_CTRL_OUT_REG_EN.
- Undefined: base behaviour above. Capacity = N; latency 1; out_data is combinational from the register file.
- Defined: adds a one-entry registered output stage (ov, od).
  - Internal dequeue from the register file happens when cnt != 0 and (ov==0 or pop). The entry loads into od with ov=1, and rd_ptr++.
  - Pop with nothing to refill clears ov.
  - out_valid=ov; out_data=od (od=0 out of reset).
  - Capacity = N+1, level = cnt + ov, full = (level == N+1). in_ready is still (cnt != N).
  - Latency 2 cycles. out_data has no combinational path from the register file.

## Test plan
- Reset then idle, N=4 → in_ready=1, out_valid=0, level=0, empty=1, out_data=0.
- Push 0xA0..0xA3 on consecutive cycles with out_ready=0 → level=4, full=1, in_ready=0. A fifth push of 0xA4 is held until space frees.
- From full, out_ready=1 for 4 cycles → outputs 0xA0,0xA1,0xA2,0xA3 in order. Then empty=1, out_valid=0.
- Sustained push and pop with values 1..12 starting at level 2 → order is preserved across ≥2 pointer wraps, level stays 2, and no bubbles occur.
- Full and in_valid=1 and out_ready=1 in the same cycle → a pop occurs, no push occurs, level goes 4→3. The push is accepted the next cycle.
- rstn asserted low for one cycle at level 3 → next cycle level=0, out_valid=0. The next push of 0x55 is output first.
- With the macro defined → first push 0x11 appears on out_data two cycles later. Five pushes with out_ready=0 give full=1 at level 5.
